// File: rtl/execute_stage_pkg.sv
// Shared definitions for the EX stage: ALU opcodes, FSM encodings,
// pipeline-register layouts and the operand-forwarding helper.
package execute_stage_pkg;

  // ALU operation codes carried in IDEXReg.alu_op
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_MUL  = 4'd12;
  localparam logic [3:0] ALU_DIVU = 4'd13;

  // Mul/div sequencing states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ID/EX register, 127 bits, MSB first
  typedef struct packed {
    logic        valid;       // [126]
    logic [4:0]  shamt;       // [125:121]
    logic        reg_write;   // [120]
    logic        mem_to_reg;  // [119]
    logic        mem_write;   // [118]
    logic        mem_read;    // [117]
    logic        reg_dst;     // [116]
    logic        alu_src;     // [115]
    logic [3:0]  alu_op;      // [114:111]
    logic [4:0]  rs;          // [110:106]
    logic [4:0]  rd;          // [105:101]
    logic [4:0]  rt;          // [100:96]
    logic [31:0] imm;         // [95:64]
    logic [31:0] rd2;         // [63:32]
    logic [31:0] rd1;         // [31:0]
  } idex_t;

  // MEM/WB register, 71 bits
  typedef struct packed {
    logic        mem_to_reg;  // [70]
    logic [31:0] addr;        // [69:38]
    logic        reg_write;   // [37]
    logic [4:0]  write_reg;   // [36:32]
    logic [31:0] rd_data;     // [31:0]
  } memwb_t;

  // EX/MEM register, 75 bits
  typedef struct packed {
    logic        reg_write;   // [74]
    logic        mem_write;   // [73]
    logic        mem_to_reg;  // [72]
    logic        mem_read;    // [71]
    logic        rsvd;        // [70] always 0
    logic        zero;        // [69]
    logic [4:0]  write_reg;   // [68:64]
    logic [31:0] write_data;  // [63:32]
    logic [31:0] alu_result;  // [31:0]
  } exmem_t;

  // Control and store data that travel with a result into EX/MEM
  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
  } ex_ctrl_t;

  // Select the freshest value of a source register; EX/MEM beats MEM/WB,
  // and loads in EX/MEM are not forwarded (their data is not ready yet).
  function automatic logic [31:0] forward_operand(input logic [4:0]  src,
                                                  input logic [31:0] rf_val,
                                                  input exmem_t      ex,
                                                  input memwb_t      wb);
    if (ex.reg_write && !ex.mem_to_reg && ex.write_reg != 5'd0 && ex.write_reg == src)
      return ex.alu_result;
    else if (wb.reg_write && wb.write_reg != 5'd0 && wb.write_reg == src)
      return wb.mem_to_reg ? wb.rd_data : wb.addr;
    else
      return rf_val;
  endfunction

  // Assemble an EX/MEM word from control and a result
  function automatic exmem_t pack_exmem(input ex_ctrl_t ctrl, input logic [31:0] result);
    exmem_t e;
    e.reg_write  = ctrl.reg_write;
    e.mem_write  = ctrl.mem_write;
    e.mem_to_reg = ctrl.mem_to_reg;
    e.mem_read   = ctrl.mem_read;
    e.rsvd       = 1'b0;
    e.zero       = (result == 32'd0);
    e.write_reg  = ctrl.write_reg;
    e.write_data = ctrl.write_data;
    e.alu_result = result;
    return e;
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Pipeline-register bundle between ID/EX, MEM/WB and the EX stage.
interface execute_stage_if
  import execute_stage_pkg::*;
();
  idex_t  IDEXReg;
  memwb_t MEMWBReg;
  exmem_t EXMEMReg;
  logic   exStall;

  // Upstream pipeline side
  modport master (output IDEXReg, output MEMWBReg, input EXMEMReg, input exStall);
  // EX stage side
  modport slave  (input IDEXReg, input MEMWBReg, output EXMEMReg, output exStall);
endinterface

// File: rtl/execute_stage_mul_div_iter.sv
// Iterative 32-bit unit: shift-add multiply (low word) and restoring
// unsigned divide, one bit per clock.
module execute_stage_mul_div_iter #(
  parameter int STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int            CW   = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  logic [CW-1:0] count;
  logic          div_q;
  // mul: acc = partial product, x = shifted multiplicand, y = multiplier
  // div: acc = remainder,       x = dividend/quotient,    y = divisor
  logic [31:0]   acc, x, y;
  logic [31:0]   acc_n, x_n, y_n;
  logic [32:0]   shifted, diff;

  assign done   = busy && (count == LAST);
  assign result = div_q ? x : acc;

  // One algorithm step from the current registers
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    acc_n   = acc;
    x_n     = x;
    y_n     = y;
    shifted = {acc, x[31]};
    diff    = shifted - {1'b0, y};
    if (div_q) begin
      if (!diff[32]) begin
        acc_n = diff[31:0];
        x_n   = {x[30:0], 1'b1};
      end else begin
        acc_n = shifted[31:0];
        x_n   = {x[30:0], 1'b0};
      end
    end else begin
      if (y[0]) acc_n = acc + x;
      x_n = {x[30:0], 1'b0};
      y_n = {1'b0, y[31:1]};
    end
  end

  // Step counter and busy flag
  always_ff @(posedge clk) begin
    // NOTE: state registers use <= so every flop samples pre-edge values.
    if (rst) begin
      busy  <= 1'b0;
      count <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      count <= '0;
    end else if (busy) begin
      count <= count + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

  // Datapath registers: loaded on start, advanced while busy
  always_ff @(posedge clk) begin
    // NOTE: datapath registers carry no reset; busy gates their use.
    if (start) begin
      acc   <= '0;
      x     <= a;
      y     <= b;
      div_q <= op_div;
    end else if (busy) begin
      acc <= acc_n;
      x   <= x_n;
      y   <= y_n;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, single-cycle ALU, mul/div sequencing and
// the EX/MEM pipeline register.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int MD_STEPS = 32
) (
  input  logic           clk,
  input  logic           rst,
  execute_stage_if.slave bus
);

  idex_t       idex;
  memwb_t      memwb;
  exmem_t      exmem_q, exmem_d;
  logic [1:0]  state, state_d;
  ex_ctrl_t    ctrl_now, ctrl_hold;
  logic [31:0] fwd_a, fwd_rt, op_b, alu_result, md_result;
  logic        is_md, md_start, md_busy, md_done;

  assign idex         = bus.IDEXReg;
  assign memwb        = bus.MEMWBReg;
  assign bus.EXMEMReg = exmem_q;
  assign bus.exStall  = md_start || md_busy;

  assign fwd_a  = forward_operand(idex.rs, idex.rd1, exmem_q, memwb);
  assign fwd_rt = forward_operand(idex.rt, idex.rd2, exmem_q, memwb);
  assign op_b   = idex.alu_src ? idex.imm : fwd_rt;

  assign ctrl_now.reg_write  = idex.reg_write;
  assign ctrl_now.mem_write  = idex.mem_write;
  assign ctrl_now.mem_to_reg = idex.mem_to_reg;
  assign ctrl_now.mem_read   = idex.mem_read;
  assign ctrl_now.write_reg  = idex.reg_dst ? idex.rd : idex.rt;
  assign ctrl_now.write_data = fwd_rt;

  assign is_md    = idex.valid && (idex.alu_op == ALU_MUL || idex.alu_op == ALU_DIVU);
  assign md_start = (state == ST_IDLE) && is_md;

  execute_stage_mul_div_iter #(.STEPS(MD_STEPS)) u_mul_div_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .op_div (idex.alu_op == ALU_DIVU),
    .a      (fwd_a),
    .b      (op_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // Single-cycle ALU
  always_comb begin
    alu_result = 32'd0;
    case (idex.alu_op)
      ALU_ADD:  alu_result = fwd_a + op_b;
      ALU_SUB:  alu_result = fwd_a - op_b;
      ALU_AND:  alu_result = fwd_a & op_b;
      ALU_OR:   alu_result = fwd_a | op_b;
      ALU_XOR:  alu_result = fwd_a ^ op_b;
      ALU_NOR:  alu_result = ~(fwd_a | op_b);
      ALU_SLT:  alu_result = {31'd0, $signed(fwd_a) < $signed(op_b)};
      ALU_SLTU: alu_result = {31'd0, fwd_a < op_b};
      ALU_SLL:  alu_result = op_b << idex.shamt;
      ALU_SRL:  alu_result = op_b >> idex.shamt;
      ALU_SRA:  alu_result = $signed(op_b) >>> idex.shamt;
      ALU_LUI:  alu_result = {idex.imm[15:0], 16'h0000};
      default:  alu_result = 32'd0;
    endcase
  end

  // Next state and next EX/MEM contents
  always_comb begin
    state_d = state;
    exmem_d = '0;
    case (state)
      ST_IDLE: begin
        if (md_start)        state_d = ST_BUSY;
        else if (idex.valid) exmem_d = pack_exmem(ctrl_now, alu_result);
      end
      ST_BUSY: if (md_done) state_d = ST_DONE;
      ST_DONE: begin
        exmem_d = pack_exmem(ctrl_hold, md_result);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and EX/MEM register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      exmem_q <= '0;
    end else begin
      state   <= state_d;
      exmem_q <= exmem_d;
    end
  end

  // Capture the control of a mul/div at issue; upstream changes afterwards are ignored
  always_ff @(posedge clk) begin
    if (md_start) ctrl_hold <= ctrl_now;
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage with an expected-result queue.
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  int     total = 0;
  int     bad = 0;
  exmem_t exp_q[$];

  always #5 clk = ~clk;

  execute_stage_if bus();

  execute_stage #(.MD_STEPS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [74:0] got, input logic [74:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference ALU on already-selected operands
  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh,
                                            input logic [31:0] imm);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return b << sh;
      4'd9:  return b >> sh;
      4'd10: return $signed(b) >>> sh;
      4'd11: return {imm[15:0], 16'h0000};
      4'd12: return a * b;
      4'd13: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic idex_t mk_op(input logic [3:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                                  input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    idex_t i;
    i = '0;
    i.valid = 1'b1; i.alu_op = op; i.rd1 = rd1; i.rd2 = rd2;
    i.rs = rs; i.rt = rt; i.rd = rd; i.reg_dst = 1'b1; i.reg_write = 1'b1;
    return i;
  endfunction

  function automatic exmem_t mk_exp(input logic [31:0] res, input logic [31:0] wdata, input logic [4:0] wreg,
                                    input logic rw, input logic mw, input logic mtr, input logic mr);
    exmem_t e;
    e = '0;
    e.alu_result = res; e.write_data = wdata; e.write_reg = wreg; e.zero = (res == 32'd0);
    e.reg_write = rw; e.mem_write = mw; e.mem_to_reg = mtr; e.mem_read = mr;
    return e;
  endfunction

  task automatic pop_check(input string tag);
    exmem_t e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: got=%0h exp=<queue empty>", tag, bus.EXMEMReg);
    end else begin
      e = exp_q.pop_front();
      check(tag, bus.EXMEMReg, e);
    end
  endtask

  // Drive one cycle of stimulus, check the stall before the edge and EX/MEM after it
  task automatic drive_cycle(input idex_t i, input memwb_t m, input logic exp_stall,
                             input exmem_t exp, input string tag);
    @(negedge clk);
    bus.IDEXReg  = i;
    bus.MEMWBReg = m;
    #1;
    check({tag, ".stall"}, 75'(bus.exStall), 75'(exp_stall));
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  // Full mul/div transaction: issue, 32 busy cycles, one result, then silence
  task automatic run_md(input idex_t i, input logic perturb, input string tag);
    exmem_t z, e;
    idex_t  p;
    z = '0;
    e = mk_exp(model_alu(i.alu_op, i.rd1, i.rd2, 5'd0, 32'd0), i.rd2,
               i.reg_dst ? i.rd : i.rt, i.reg_write, 1'b0, 1'b0, 1'b0);
    p = i;
    if (perturb) begin p.rd1 = ~i.rd1; p.rd2 = i.rd2 + 32'd3; p.rd = 5'd30; end
    drive_cycle(i, '0, 1'b1, z, {tag, ".issue"});
    for (int k = 0; k < 32; k++) drive_cycle(p, '0, 1'b1, z, {tag, ".busy"});
    drive_cycle(i, '0, 1'b0, e, {tag, ".done"});
    drive_cycle('0, '0, 1'b0, z, {tag, ".nodup"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idex_t  i;
    memwb_t m;
    exmem_t z;
    logic [31:0] ta [14];
    logic [31:0] tb [14];
    logic [3:0]  top [14];
    logic [4:0]  tsh [14];

    z = '0;
    rst = 1'b1;
    bus.IDEXReg  = '0;
    bus.MEMWBReg = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.exmem", bus.EXMEMReg, 75'd0);
    check("reset.stall", 75'(bus.exStall), 75'd0);

    // ADD 5+7 -> r3
    i = mk_op(ALU_ADD, 32'd5, 32'd7, 5'd0, 5'd0, 5'd3);
    drive_cycle(i, '0, 1'b0, mk_exp(32'd12, 32'd7, 5'd3, 1, 0, 0, 0), "add");

    // SUB r3-2 with EX/MEM and MEM/WB both targeting r3: EX/MEM wins
    m = '0; m.reg_write = 1'b1; m.write_reg = 5'd3; m.addr = 32'd99;
    i = mk_op(ALU_SUB, 32'd0, 32'd2, 5'd3, 5'd5, 5'd4);
    drive_cycle(i, m, 1'b0, mk_exp(32'd10, 32'd2, 5'd4, 1, 0, 0, 0), "sub.fwd_exmem");

    // OR: rs from MEM/WB (99), rt from EX/MEM (10)
    i = mk_op(ALU_OR, 32'd0, 32'd0, 5'd3, 5'd4, 5'd6);
    drive_cycle(i, m, 1'b0, mk_exp(32'd107, 32'd10, 5'd6, 1, 0, 0, 0), "or.fwd_both");

    // LW r11 <- [100+4]; a following read of r11 must not take the address from EX/MEM
    i = mk_op(ALU_ADD, 32'd100, 32'd0, 5'd1, 5'd11, 5'd0);
    i.reg_dst = 1'b0; i.alu_src = 1'b1; i.imm = 32'd4; i.mem_read = 1'b1; i.mem_to_reg = 1'b1;
    drive_cycle(i, '0, 1'b0, mk_exp(32'd104, 32'd0, 5'd11, 1, 0, 1, 1), "lw");
    i = mk_op(ALU_ADD, 32'd5, 32'd1, 5'd11, 5'd0, 5'd12);
    drive_cycle(i, '0, 1'b0, mk_exp(32'd6, 32'd1, 5'd12, 1, 0, 0, 0), "add.no_load_fwd");

    // SW: store data forwarded from MEM/WB load data
    m = '0; m.reg_write = 1'b1; m.mem_to_reg = 1'b1; m.write_reg = 5'd9;
    m.rd_data = 32'hDEAD_BEEF; m.addr = 32'd5;
    i = mk_op(ALU_ADD, 32'd4, 32'd0, 5'd1, 5'd9, 5'd0);
    i.reg_dst = 1'b0; i.reg_write = 1'b0; i.alu_src = 1'b1; i.imm = 32'd8; i.mem_write = 1'b1;
    drive_cycle(i, m, 1'b0, mk_exp(32'd12, 32'hDEAD_BEEF, 5'd9, 0, 1, 0, 0), "sw");

    // Bubble
    drive_cycle('0, '0, 1'b0, z, "bubble");

    // ALU table
    top = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
            ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, 4'd14, 4'd15};
    ta  = '{32'hFFFF_FFFF, 32'd3, 32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_F0F0, 32'd0,
            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd9, 32'd9};
    tb  = '{32'd1, 32'd5, 32'h0000_FF00, 32'h0000_FF00, 32'h0000_FF00, 32'd0,
            32'd1, 32'd1, 32'd1, 32'h8000_0000, 32'h8000_0000, 32'd7, 32'd9, 32'd9};
    tsh = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd4, 5'd4, 5'd0, 5'd0, 5'd0};
    for (int k = 0; k < 14; k++) begin
      i = mk_op(top[k], ta[k], tb[k], 5'd0, 5'd0, 5'd7);
      i.shamt = tsh[k];
      i.imm = 32'h0000_1234;
      drive_cycle(i, '0, 1'b0,
                  mk_exp(model_alu(top[k], ta[k], tb[k], tsh[k], 32'h0000_1234), tb[k], 5'd7, 1, 0, 0, 0),
                  $sformatf("alu.op%0d", top[k]));
    end

    // Mul/div
    run_md(mk_op(ALU_MUL, 32'h0001_0003, 32'h0000_0010, 5'd0, 5'd0, 5'd8), 1'b0, "mul");
    run_md(mk_op(ALU_DIVU, 32'd100, 32'd7, 5'd0, 5'd0, 5'd13), 1'b1, "divu");
    run_md(mk_op(ALU_DIVU, 32'd12345, 32'd0, 5'd0, 5'd0, 5'd14), 1'b0, "divu0");

    // Reset during BUSY cycle 10 aborts without a result
    i = mk_op(ALU_DIVU, 32'd1000, 32'd3, 5'd0, 5'd0, 5'd15);
    drive_cycle(i, '0, 1'b1, z, "abort.issue");
    for (int k = 0; k < 10; k++) drive_cycle(i, '0, 1'b1, z, "abort.busy");
    @(negedge clk);
    rst = 1'b1;
    bus.IDEXReg = '0;
    exp_q.push_back(z);
    @(posedge clk);
    #1;
    pop_check("abort.rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort.stall", 75'(bus.exStall), 75'd0);
    for (int k = 0; k < 30; k++) drive_cycle('0, '0, 1'b0, z, "abort.quiet");

    // Unit usable again after the abort: -3 * 5, written via rt
    i = mk_op(ALU_MUL, 32'hFFFF_FFFD, 32'd5, 5'd0, 5'd10, 5'd0);
    i.reg_dst = 1'b0;
    run_md(i, 1'b0, "mul.after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
